// File: rtl/mips16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips16_pkg
// Description : Shared definitions for the 16-bit pipelined datapath:
//               word/PC widths, opcode constants, NOP encoding, instruction
//               field bit positions and an immediate sign-extend helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mips16_pkg;

  localparam int WORD_W = 16;
  localparam int PC_W   = 16;

  // Opcode encodings
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1010;
  localparam logic [3:0] OP_BNE = 4'b1110;

  localparam logic [WORD_W-1:0] NOP_INSTR = 16'h0000;

  // Instruction field bit positions: {opcode, rs, rt, imm}
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int RS_MSB     = 11;
  localparam int RS_LSB     = 8;
  localparam int RT_MSB     = 7;
  localparam int RT_LSB     = 4;
  localparam int IMM_MSB    = 3;
  localparam int IMM_LSB    = 0;

  // Sign-extend a 4-bit two's complement field to a full word.
  function automatic logic [WORD_W-1:0] sext_imm4(input logic [3:0] v);
    return {{(WORD_W-4){v[3]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register. Holds on stall, loads a bubble on
//               flush, otherwise captures the fetched instruction and its PC.
//               Also exposes the decoded instruction fields.
// Ports       : clk, rst        - clock, async active-high reset
//               i_stall         - hold current contents (highest priority)
//               i_flush         - load bubble (instr=0, pc=0, valid=0)
//               i_instr, i_pc   - fetched instruction and its address
//               o_instr, o_pc, o_valid - register contents
//               o_opcode, o_rs, o_rt, o_imm_sext - field slices of o_instr
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
  import mips16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic [WORD_W-1:0] i_instr,
  input  logic [PC_W-1:0]   i_pc,
  output logic [WORD_W-1:0] o_instr,
  output logic [PC_W-1:0]   o_pc,
  output logic              o_valid,
  output logic [3:0]        o_opcode,
  output logic [3:0]        o_rs,
  output logic [3:0]        o_rt,
  output logic [WORD_W-1:0] o_imm_sext
);

  logic [WORD_W-1:0] r_instr;
  logic [PC_W-1:0]   r_pc;
  logic              r_valid;

  // Stall is checked before flush so a stalled cycle never squashes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (!i_stall) begin
      if (i_flush) begin
        r_instr <= NOP_INSTR;
        r_pc    <= '0;
        r_valid <= 1'b0;
      end else begin
        r_instr <= i_instr;
        r_pc    <= i_pc;
        r_valid <= 1'b1;
      end
    end
  end

  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_valid    = r_valid;
  assign o_opcode   = r_instr[OPCODE_MSB:OPCODE_LSB];
  assign o_rs       = r_instr[RS_MSB:RS_LSB];
  assign o_rt       = r_instr[RT_MSB:RT_LSB];
  assign o_imm_sext = sext_imm4(r_instr[IMM_MSB:IMM_LSB]);

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage
// Description : Instruction-fetch stage. Owns the program counter, the
//               next-PC mux/adder (sequential or taken-branch target) and
//               the accepted-fetch counter; instantiates the IF/ID register.
// Ports       : clk, rst     - clock, async active-high reset
//               pc_out       - word address to instruction memory
//               instr_in     - instruction memory data for pc_out
//               stall        - hold PC, IF/ID and fetch_count
//               br_taken     - IF/ID holds a taken branch
//               br_off       - signed 4-bit word offset of that branch
//               id_instr, id_pc, id_valid - IF/ID contents
//               id_opcode, id_rs, id_rt, id_imm_sext - IF/ID field slices
//               fetch_count  - instructions accepted into IF/ID (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage
  import mips16_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   pc_out,
  input  logic [WORD_W-1:0] instr_in,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [3:0]        br_off,
  output logic [WORD_W-1:0] id_instr,
  output logic [PC_W-1:0]   id_pc,
  output logic              id_valid,
  output logic [3:0]        id_opcode,
  output logic [3:0]        id_rs,
  output logic [3:0]        id_rt,
  output logic [WORD_W-1:0] id_imm_sext,
  output logic [15:0]       fetch_count
);

  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_fetch_count;
  logic [PC_W-1:0] w_pc_next;
  logic [PC_W-1:0] w_br_target;
  logic            w_flush;
  logic            w_accept;

  // A branch only redirects when the IF/ID slot holds a real instruction.
  assign w_flush     = br_taken & id_valid;
  assign w_accept    = ~stall & ~w_flush;
  assign w_br_target = id_pc + 16'd1 + sext_imm4(br_off);

  always_comb begin
    w_pc_next = r_pc;
    if (!stall) begin
      if (w_flush) begin
        w_pc_next = w_br_target;
      end else begin
        w_pc_next = r_pc + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_fetch_count <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (w_accept) begin
        r_fetch_count <= r_fetch_count + 16'd1;
      end
    end
  end

  assign pc_out      = r_pc;
  assign fetch_count = r_fetch_count;

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .i_stall    (stall),
    .i_flush    (w_flush),
    .i_instr    (instr_in),
    .i_pc       (r_pc),
    .o_instr    (id_instr),
    .o_pc       (id_pc),
    .o_valid    (id_valid),
    .o_opcode   (id_opcode),
    .o_rs       (id_rs),
    .o_rt       (id_rt),
    .o_imm_sext (id_imm_sext)
  );

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_stage
// Description : Directed self-checking bench for if_fetch_stage. One
//               instance at RESET_PC=0 with a small instruction memory,
//               a second at RESET_PC=16'hFFFF for wrap-around cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

  logic clk;
  logic rst;

  // Instance 0 (RESET_PC = 0)
  logic [15:0] pc0, instr0, id_instr0, id_pc0, imm0, fc0;
  logic        stall0, br0, valid0;
  logic [3:0]  off0, op0, rs0, rt0;
  logic [15:0] mem0 [0:255];

  // Instance 1 (RESET_PC = 16'hFFFF)
  logic [15:0] pc1, instr1, id_instr1, id_pc1, imm1, fc1;
  logic        stall1, br1, valid1;
  logic [3:0]  off1, op1, rs1, rt1;

  int n_checks = 0;
  int n_pass   = 0;

  assign instr0 = mem0[pc0[7:0]];
  assign instr1 = 16'hE001;

  if_fetch_stage #(.RESET_PC(16'h0000)) u_dut0 (
    .clk(clk), .rst(rst), .pc_out(pc0), .instr_in(instr0), .stall(stall0),
    .br_taken(br0), .br_off(off0), .id_instr(id_instr0), .id_pc(id_pc0),
    .id_valid(valid0), .id_opcode(op0), .id_rs(rs0), .id_rt(rt0),
    .id_imm_sext(imm0), .fetch_count(fc0)
  );

  if_fetch_stage #(.RESET_PC(16'hFFFF)) u_dut1 (
    .clk(clk), .rst(rst), .pc_out(pc1), .instr_in(instr1), .stall(stall1),
    .br_taken(br1), .br_off(off1), .id_instr(id_instr1), .id_pc(id_pc1),
    .id_valid(valid1), .id_opcode(op1), .id_rs(rs1), .id_rt(rt1),
    .id_imm_sext(imm1), .fetch_count(fc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compact view of instance 0 state: pc, id_pc, id_instr, valid, fetch_count
  task automatic check_state0(input string tag, input logic [15:0] e_pc,
                              input logic [15:0] e_idpc, input logic [15:0] e_instr,
                              input logic e_valid, input logic [15:0] e_fc);
    check_eq({tag, ".pc"},    pc0,             e_pc);
    check_eq({tag, ".id_pc"}, id_pc0,          e_idpc);
    check_eq({tag, ".instr"}, id_instr0,       e_instr);
    check_eq({tag, ".valid"}, {15'd0, valid0}, {15'd0, e_valid});
    check_eq({tag, ".fc"},    fc0,             e_fc);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem0[i] = 16'h1000 | 16'(i);
    mem0[0] = 16'h2624;
    mem0[1] = 16'h6627;
    stall0 = 1'b0; br0 = 1'b0; off0 = 4'd0;
    stall1 = 1'b0; br1 = 1'b0; off1 = 4'd0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #2;
    // Reset values, before any clock edge
    check_state0("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    check_eq("reset.opcode", {12'd0, op0}, 16'h0000);
    check_eq("reset.imm",    imm0,         16'h0000);
    check_eq("reset1.pc",    pc1,          16'hFFFF);
    check_eq("reset1.fc",    fc1,          16'h0000);
    #3 rst = 1'b0;

    // First fetch
    tick();
    check_state0("fetch1", 16'h0001, 16'h0000, 16'h2624, 1'b1, 16'h0001);
    check_eq("fetch1.opcode", {12'd0, op0}, 16'h0002);
    check_eq("fetch1.rs",     {12'd0, rs0}, 16'h0006);
    check_eq("fetch1.rt",     {12'd0, rt0}, 16'h0002);
    check_eq("fetch1.imm",    imm0,         16'h0004);
    check_eq("wrap.pc",       pc1,          16'h0000);
    check_eq("wrap.id_pc",    id_pc1,       16'hFFFF);
    check_eq("wrap.valid",    {15'd0, valid1}, 16'h0001);
    br1 = 1'b1; off1 = 4'b0001;

    // Second fetch; instance 1 branches from FFFF by +1
    tick();
    check_state0("fetch2", 16'h0002, 16'h0001, 16'h6627, 1'b1, 16'h0002);
    check_eq("fetch2.imm", imm0, 16'h0007);
    check_eq("wrapbr.pc",  pc1,  16'h0001);
    check_eq("wrapbr.valid", {15'd0, valid1}, 16'h0000);
    check_eq("wrapbr.fc",  fc1,  16'h0001);
    br1 = 1'b0;

    // Stall for three cycles
    stall0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_state0("stall", 16'h0002, 16'h0001, 16'h6627, 1'b1, 16'h0002);
    end
    stall0 = 1'b0;
    tick();
    check_state0("unstall", 16'h0003, 16'h0002, 16'h1002, 1'b1, 16'h0003);

    // Run until id_pc = 7
    for (int i = 0; i < 5; i++) tick();
    check_state0("run7", 16'h0008, 16'h0007, 16'h1007, 1'b1, 16'h0008);

    // Taken branch, offset -3: target 7+1-3 = 5
    br0 = 1'b1; off0 = 4'b1101;
    tick();
    check_state0("redir", 16'h0005, 16'h0000, 16'h0000, 1'b0, 16'h0008);
    // br_taken left high over the bubble: must be ignored
    tick();
    check_state0("target", 16'h0006, 16'h0005, 16'h1005, 1'b1, 16'h0009);

    // Stall together with branch: full hold
    stall0 = 1'b1; br0 = 1'b1; off0 = 4'b0010;
    tick();
    check_state0("stallbr", 16'h0006, 16'h0005, 16'h1005, 1'b1, 16'h0009);
    // Branch alone now redirects: 5+1+2 = 8
    stall0 = 1'b0;
    tick();
    check_state0("br2", 16'h0008, 16'h0000, 16'h0000, 1'b0, 16'h0009);
    br0 = 1'b0;
    tick();
    check_state0("br2tgt", 16'h0009, 16'h0008, 16'h1008, 1'b1, 16'h000A);
    check_eq("br2tgt.imm", imm0, 16'hFFF8);

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    check_state0("areset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    check_eq("areset.opcode", {12'd0, op0}, 16'h0000);
    check_eq("areset.imm",    imm0,         16'h0000);
    check_eq("areset1.pc",    pc1,          16'hFFFF);
    #2 rst = 1'b0;
    tick();
    check_state0("restart", 16'h0001, 16'h0000, 16'h2624, 1'b1, 16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage for the 16-bit pipelined datapath. It holds the program counter and drives it to the instruction memory as a word address. It captures the returned instruction into the IF/ID pipeline register for the decode stage. It also handles hazard-unit stalls and taken-branch redirects resolved in decode, flushing the wrong-path instruction.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- pc_out  out  16  current PC (word index) to instruction memory PCaddr; direct from PC register.
- instr_in  in  16  instruction returned combinationally by instruction memory for pc_out.
- stall  in  1  hazard unit: hold PC and IF/ID.
- br_taken  in  1  decode stage: instruction in IF/ID is a taken BNE.
- br_off  in  4  signed word offset, two's complement, from id_instr[3:0].
- id_instr  out  16  IF/ID instruction.
- id_pc  out  16  PC of id_instr.
- id_valid  out  1  IF/ID holds a real instruction; 0 means bubble.
- id_opcode  out  4  id_instr[15:12].
- id_rs  out  4  id_instr[11:8].
- id_rt  out  4  id_instr[7:4].
- id_imm_sext  out  16  id_instr[3:0] sign-extended to 16 bits.
- fetch_count  out  16  count of instructions accepted into IF/ID; wraps modulo 2^16.

## Operation
Registered state:
- PC.
- IF/ID {instr, pc, valid}.
- fetch_count.

Field outputs are combinational slices of id_instr.

At each rising edge, the first matching rule applies:
1. stall=1: PC, IF/ID and fetch_count all hold. br_taken is ignored, and the hazard unit must re-present the branch after the stall.
2. br_taken=1 and id_valid=1:
   - PC <= id_pc + 1 + sext(br_off), truncated to 16 bits.
   - IF/ID <= bubble (instr=16'h0000, pc=16'h0000, valid=0).
   - fetch_count holds, because the wrong-path fetch is squashed.
3. Otherwise (br_taken with id_valid=0 is ignored):
   - PC <= PC + 1, modulo 2^16.
   - IF/ID <= {instr_in, PC, 1}.
   - fetch_count <= fetch_count + 1.

Arithmetic rules:
- All PC arithmetic is unsigned 16-bit with wrap-around.
- br_off is a 4-bit signed value, so the target range is id_pc-7 to id_pc+8.

## Timing
- Reset (asynchronous, immediate, independent of clk):
  - pc_out = RESET_PC.
  - id_instr, id_pc and fetch_count = 0.
  - id_valid = 0.
  - Derived field outputs = 0.
- Fetch latency: the instruction at address A appears on id_instr one edge after pc_out = A, provided there is no stall.
- Redirect cost: one bubble cycle per taken branch. The target address is on pc_out immediately after the redirect edge, and its instruction reaches IF/ID one edge later.
- instr_in is sampled only at the capturing edge. Memory must settle within the same cycle as pc_out.
- Reset released mid-stream: fetching restarts at RESET_PC. No state from before reset survives.

## Structure
- Shared package mips16_pkg holds:
  - Opcode constants: ADD 4'b0010, SUB 4'b0110, AND 4'b0000, OR 4'b0001, SLT 4'b0111, LW 4'b1000, SW 4'b1010, BNE 4'b1110.
  - NOP_INSTR = 16'h0000.
  - Field bit positions.
  - The 16-bit word and PC width constants.
- One sub-module, if_id_reg, contains:
  - The IF/ID register with stall-hold and flush-to-bubble.
  - Field/sign-extend slicing.
- The top level contains the PC register, the next-PC mux/adder and fetch_count.

## Test plan
- Reset then run, with memory[0]=16'h2624 and memory[1]=16'h6627:
  - After the first edge: id_instr=16'h2624, id_pc=0, id_valid=1, pc_out=1, id_opcode=4'b0010, id_rs=6, id_rt=2, id_imm_sext=16'h0004.
  - After the second edge: id_instr=16'h6627, id_imm_sext=16'h0007, fetch_count=2.
- Stall held for 3 cycles with pc_out=2, id_pc=1 -> pc_out, id_pc, id_instr and fetch_count are unchanged. After release, the next edge gives id_pc=2.
- Branch with id_pc=7, br_taken=1, br_off=4'b1101 (-3):
  - After the redirect edge: pc_out=5, id_valid=0, id_instr=16'h0000, fetch_count unchanged.
  - After the following edge: id_pc=5, id_valid=1.
- Simultaneous stall=1 and br_taken=1 -> full hold, no redirect. Then br_taken=1 alone -> redirect occurs.
- Wrap-around:
  - RESET_PC=16'hFFFF -> pc_out sequence is 16'hFFFF then 16'h0000.
  - Branch at id_pc=16'hFFFF with br_off=+1 -> pc_out=16'h0001.
- Asynchronous reset asserted between clock edges mid-run -> all outputs return to reset values before the next edge. The first fetch after release is RESET_PC.
